// File: rtl/fetch_pc_stage_pkg.sv
// Shared CPU definitions for the fetch stage, next-PC unit and decode.
// Holds the fetch FSM state enum and the datapath width constants.
package fetch_pc_stage_pkg;

    // Datapath widths shared by the fetch, next-PC and decode stages.
    localparam int CPU_PC_WIDTH    = 32;
    localparam int CPU_INSTR_WIDTH = 32;

    // Word address of the first instruction fetched after reset.
    localparam int unsigned CPU_RESET_PC = 32'd0;

    // Fetch sequencer states.
    //   S_RESET : one-cycle bubble after reset, no request
    //   S_FETCH : request outstanding, IF/ID empty
    //   S_FULL  : IF/ID occupied, request only when decode drains it
    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_stage_if.sv
// Fetch-side bus bundle: instruction memory req/ack plus the IF/ID
// valid/ready hand-off to decode. master = fetch stage, slave = env.
interface fetch_pc_stage_if
    import fetch_pc_stage_pkg::*;
#(
    parameter int PC_WIDTH    = CPU_PC_WIDTH,
    parameter int INSTR_WIDTH = CPU_INSTR_WIDTH
);

    // Instruction memory request channel
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    // IF/ID hand-off to decode
    logic                   if_valid;
    logic [INSTR_WIDTH-1:0] if_instr;
    logic [PC_WIDTH-1:0]    if_pc;
    logic                   id_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output if_valid,
        output if_instr,
        output if_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output id_ready
    );

endinterface

// File: rtl/fetch_pc_stage_if_id_reg.sv
// IF/ID pipeline register with load / hold / clear controls.
// Ports: clk, reset, load, clear, instr_in, pc_in -> valid, instr, pc.
module if_id_reg #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   clear,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic [PC_WIDTH-1:0]    pc_in,
    output logic                   valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    pc
);

    // Clear only drops valid; the stale payload is harmless because
    // decode ignores it and keeping it avoids extra enable fan-out.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction fetch stage: owns the PC, issues word fetches over
// req/ack and fills IF/ID. Ports: clk, reset, pc_out/pc_next_in to
// the next-PC unit, flush/flush_pc redirect, bus (imem + IF/ID).
module fetch_pc_stage
    import fetch_pc_stage_pkg::*;
#(
    parameter int PC_WIDTH    = CPU_PC_WIDTH,
    parameter int INSTR_WIDTH = CPU_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(CPU_RESET_PC)
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] pc_out,
    input  logic [PC_WIDTH-1:0] pc_next_in,
    input  logic                flush,
    input  logic [PC_WIDTH-1:0] flush_pc,
    fetch_pc_stage_if.master    bus
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic [PC_WIDTH-1:0]    pc_q;
    logic                   fetch_req;
    logic                   accept;
    logic                   ifid_load;
    logic                   ifid_clear;
    logic                   ifid_valid;
    logic [INSTR_WIDTH-1:0] ifid_instr;
    logic [PC_WIDTH-1:0]    ifid_pc;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Architectural PC: a redirect wins over the next-PC result, and
    // the next-PC result is only taken when a fetch is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (flush) begin
            pc_q <= flush_pc;
        end else if (accept) begin
            pc_q <= pc_next_in;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_FETCH;
        end else begin
            unique case (state_q)
                S_RESET: state_d = S_FETCH;
                S_FETCH: begin
                    if (accept) begin
                        state_d = S_FULL;
                    end
                end
                S_FULL: begin
                    if (bus.id_ready && !accept) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_RESET;
            endcase
        end
    end

    // Output logic
    always_comb begin
        fetch_req = 1'b0;
        unique case (state_q)
            S_FETCH: fetch_req = 1'b1;
            // Refill as soon as decode drains the slot, giving one
            // instruction per cycle with a zero-wait memory.
            S_FULL:  fetch_req = bus.id_ready;
            default: fetch_req = 1'b0;
        endcase
        // Dropping req lets memory abandon an unacknowledged fetch,
        // which also turns any coincident ack into a no-op.
        if (reset || flush) begin
            fetch_req = 1'b0;
        end
        accept     = fetch_req && bus.imem_ack;
        ifid_load  = accept;
        ifid_clear = flush
                  || (state_q == S_FULL && bus.id_ready && !accept);
    end

    if_id_reg #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (ifid_load),
        .clear    (ifid_clear),
        .instr_in (bus.imem_rdata),
        .pc_in    (pc_q),
        .valid    (ifid_valid),
        .instr    (ifid_instr),
        .pc       (ifid_pc)
    );

    assign pc_out        = pc_q;
    assign bus.imem_req  = fetch_req;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = ifid_valid;
    assign bus.if_instr  = ifid_instr;
    assign bus.if_pc     = ifid_pc;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Self-checking bench for fetch_pc_stage: directed scenarios plus a
// randomized run against a queue-based IF/ID reference model.
module tb_fetch_pc_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_out;
    logic [31:0] pc_next_in;
    logic        flush;
    logic [31:0] flush_pc;

    fetch_pc_stage_if bus ();

    fetch_pc_stage dut (
        .clk        (clk),
        .reset      (reset),
        .pc_out     (pc_out),
        .pc_next_in (pc_next_in),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Environment knobs
    int          lat = 0;
    bit          ack_force = 1'b0;
    bit          rand_np = 1'b0;
    bit          br_en = 1'b0;
    logic [31:0] br_from = '0;
    logic [31:0] br_to = '0;
    int          wait_cnt = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        if (a == 32'd7) return 32'hE3A01005;
        return (a * 32'h9E3779B1) ^ 32'h5BD1E995;
    endfunction

    function automatic logic [31:0] next_of(input logic [31:0] a);
        if (a % 32'd7 == 32'd3) return a + 32'd500;
        return a + 32'd1;
    endfunction

    // Next-PC unit stand-in
    always_comb begin
        pc_next_in = pc_out + 32'd1;
        if (br_en && pc_out == br_from) pc_next_in = br_to;
        else if (rand_np) pc_next_in = next_of(pc_out);
    end

    // Instruction memory: acks after `lat` unacked request cycles
    always @(negedge clk) begin
        #1;
        bus.imem_rdata = instr_of(bus.imem_addr);
        bus.imem_ack = ack_force || (bus.imem_req && wait_cnt >= lat);
        if (!bus.imem_req || bus.imem_ack) wait_cnt = 0;
        else wait_cnt++;
    end

    task automatic restart();
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b0;
        flush_pc = '0;
        bus.id_ready = 1'b1;
        ack_force = 1'b0;
        lat = 0;
        br_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #2;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b0;
        flush_pc = '0;
        bus.id_ready = 1'b1;
        @(negedge clk);
        #2;
        n_total++;
        if (pc_out !== 32'd0)
            $display("FAIL rst_pc got %h exp 0", pc_out);
        else n_pass++;
        n_total++;
        if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'd0
            || bus.if_pc !== 32'd0)
            $display("FAIL rst_ifid got v%b i%h p%h exp 0",
                     bus.if_valid, bus.if_instr, bus.if_pc);
        else n_pass++;
        n_total++;
        if (bus.imem_req !== 1'b0)
            $display("FAIL rst_req got %b exp 0", bus.imem_req);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #2;
        n_total++;
        if (bus.imem_req !== 1'b0)
            $display("FAIL bubble_req got %b exp 0", bus.imem_req);
        else n_pass++;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            n_total++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(i))
                $display("FAIL stream_addr[%0d] got r%b a%0d exp r1 a%0d",
                         i, bus.imem_req, bus.imem_addr, i);
            else n_pass++;
            if (i > 0) begin
                n_total++;
                if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(i - 1)
                    || bus.if_instr !== instr_of(32'(i - 1)))
                    $display("FAIL stream_ifid[%0d] got v%b p%0d exp v1 p%0d",
                             i, bus.if_valid, bus.if_pc, i - 1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_latency();
        restart();
        @(negedge clk);
        flush = 1'b1;
        flush_pc = 32'd5;
        lat = 3;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #2;
            n_total++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd5
                || bus.if_valid !== 1'b0)
                $display("FAIL lat_hold[%0d] got r%b a%0d v%b exp r1 a5 v0",
                         i, bus.imem_req, bus.imem_addr, bus.if_valid);
            else n_pass++;
        end
        @(negedge clk);
        lat = 0;
        #2;
        n_total++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd5
            || bus.if_instr !== instr_of(32'd5) || pc_out !== 32'd6)
            $display("FAIL lat_done got v%b p%0d pc%0d exp v1 p5 pc6",
                     bus.if_valid, bus.if_pc, pc_out);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        restart();
        @(negedge clk);
        flush = 1'b1;
        flush_pc = 32'd7;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.id_ready = 1'b0;
            #2;
            n_total++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd7
                || bus.if_instr !== 32'hE3A01005 || pc_out !== 32'd8
                || bus.imem_req !== 1'b0)
                $display("FAIL bp_hold[%0d] got v%b p%0d i%h pc%0d r%b",
                         i, bus.if_valid, bus.if_pc, bus.if_instr,
                         pc_out, bus.imem_req);
            else n_pass++;
        end
        @(negedge clk);
        bus.id_ready = 1'b1;
        #2;
        n_total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd8
            || bus.if_pc !== 32'd7)
            $display("FAIL bp_release got r%b a%0d p%0d exp r1 a8 p7",
                     bus.imem_req, bus.imem_addr, bus.if_pc);
        else n_pass++;
        @(negedge clk);
        #2;
        n_total++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd8)
            $display("FAIL bp_next got v%b p%0d exp v1 p8",
                     bus.if_valid, bus.if_pc);
        else n_pass++;
    endtask

    task automatic test_branch();
        restart();
        br_en = 1'b1;
        br_from = 32'd234;
        br_to = 32'd734;
        @(negedge clk);
        flush = 1'b1;
        flush_pc = 32'd234;
        @(negedge clk);
        flush = 1'b0;
        #2;
        n_total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd234)
            $display("FAIL br_req got r%b a%0d exp r1 a234",
                     bus.imem_req, bus.imem_addr);
        else n_pass++;
        @(negedge clk);
        #2;
        n_total++;
        if (bus.imem_addr !== 32'd734 || bus.if_pc !== 32'd234)
            $display("FAIL br_target got a%0d p%0d exp a734 p234",
                     bus.imem_addr, bus.if_pc);
        else n_pass++;
        br_en = 1'b0;
    endtask

    task automatic test_flush();
        restart();
        @(negedge clk);
        @(negedge clk);
        #2;
        n_total++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd0)
            $display("FAIL fl_pre got v%b p%0d exp v1 p0",
                     bus.if_valid, bus.if_pc);
        else n_pass++;
        @(negedge clk);
        flush = 1'b1;
        flush_pc = 32'h40;
        ack_force = 1'b1;
        #2;
        n_total++;
        if (bus.imem_req !== 1'b0)
            $display("FAIL fl_req got %b exp 0", bus.imem_req);
        else n_pass++;
        @(negedge clk);
        flush = 1'b0;
        ack_force = 1'b0;
        #2;
        n_total++;
        if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1
            || bus.imem_addr !== 32'h40)
            $display("FAIL fl_after got v%b r%b a%h exp v0 r1 a40",
                     bus.if_valid, bus.imem_req, bus.imem_addr);
        else n_pass++;
        @(negedge clk);
        #2;
        n_total++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h40)
            $display("FAIL fl_refill got v%b p%h exp v1 p40",
                     bus.if_valid, bus.if_pc);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        restart();
        @(negedge clk);
        #2;
        lat = 5;
        @(negedge clk);
        #2;
        n_total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd1
            || bus.if_valid !== 1'b1)
            $display("FAIL rm_pending got r%b a%0d v%b exp r1 a1 v1",
                     bus.imem_req, bus.imem_addr, bus.if_valid);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        #2;
        n_total++;
        if (bus.imem_req !== 1'b0)
            $display("FAIL rm_req got %b exp 0", bus.imem_req);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        lat = 0;
        #2;
        n_total++;
        if (bus.if_valid !== 1'b0 || pc_out !== 32'd0
            || bus.imem_req !== 1'b0)
            $display("FAIL rm_bubble got v%b pc%0d r%b exp v0 pc0 r0",
                     bus.if_valid, pc_out, bus.imem_req);
        else n_pass++;
        @(negedge clk);
        #2;
        n_total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0)
            $display("FAIL rm_refetch got r%b a%0d exp r1 a0",
                     bus.imem_req, bus.imem_addr);
        else n_pass++;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    // Model: one-deep IF/ID slot; fetch whenever the slot will be free.
    task automatic test_random();
        ent_t        q[$];
        logic [31:0] exp_pc;
        bit          exp_req;
        ent_t        e;
        rand_np = 1'b1;
        restart();
        exp_pc = 32'd0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.id_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            flush_pc = $urandom;
            ack_force = flush && ($urandom_range(0, 1) == 1);
            lat = $urandom_range(0, 2);
            #2;
            exp_req = !flush && (q.size() == 0 || bus.id_ready);
            n_total++;
            if (bus.imem_req !== exp_req || bus.imem_addr !== exp_pc
                || pc_out !== exp_pc)
                $display("FAIL rnd_fetch[%0d] got r%b a%h pc%h exp r%b a%h",
                         c, bus.imem_req, bus.imem_addr, pc_out,
                         exp_req, exp_pc);
            else n_pass++;
            n_total++;
            if (bus.if_valid !== (q.size() != 0))
                $display("FAIL rnd_valid[%0d] got %b exp %b",
                         c, bus.if_valid, q.size() != 0);
            else n_pass++;
            if (q.size() != 0) begin
                n_total++;
                if (bus.if_pc !== q[0].pc || bus.if_instr !== q[0].ins)
                    $display("FAIL rnd_ifid[%0d] got p%h i%h exp p%h i%h",
                             c, bus.if_pc, bus.if_instr, q[0].pc, q[0].ins);
                else n_pass++;
            end
            if (flush) begin
                q.delete();
                exp_pc = flush_pc;
            end else begin
                if (q.size() != 0 && bus.id_ready) void'(q.pop_front());
                if (exp_req && bus.imem_ack) begin
                    e.pc = exp_pc;
                    e.ins = instr_of(exp_pc);
                    q.push_back(e);
                    exp_pc = next_of(exp_pc);
                end
            end
        end
        rand_np = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        flush_pc = '0;
        bus.id_ready = 1'b1;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        test_reset();
        test_stream();
        test_latency();
        test_backpressure();
        test_branch();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_pc_stage.md
Name: fetch_pc_stage

Overview:
Instruction-fetch stage that owns the architectural program counter register and sits directly upstream of the next-PC unit and the decode stage. It issues word-addressed requests to instruction memory using a req/ack handshake. It latches the returned instruction with its PC into an IF/ID output register, and loads the next-PC unit's result into the PC on each accepted fetch. It supports decode back-pressure and a flush/redirect that abandons any in-flight fetch.

Parameters:
PC_WIDTH, 32, width of PC and memory address (word-addressed, +1 per instruction)
INSTR_WIDTH, 32, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
pc_out  output  PC_WIDTH  current PC; drives the next-PC unit's program_counter input
pc_next_in  input  PC_WIDTH  program_counter_next from the next-PC unit
flush  input  1  redirect request from execute
flush_pc  input  PC_WIDTH  redirect target
imem_req  output  1  fetch request
imem_addr  output  PC_WIDTH  fetch address, equal to pc_out
imem_ack  input  1  instruction valid this cycle
imem_rdata  input  INSTR_WIDTH  instruction word
if_valid  output  1  IF/ID register holds an instruction
if_instr  output  INSTR_WIDTH  fetched instruction
if_pc  output  PC_WIDTH  PC of if_instr
id_ready  input  1  decode accepts IF/ID this cycle

Behaviour:
- FSM states:
  - S_RESET: one-cycle post-reset bubble.
  - S_FETCH: request outstanding.
  - S_FULL: IF/ID occupied, no request.
- Reset, taking priority over everything:
  - state=S_RESET, pc=RESET_PC.
  - if_valid=0, if_instr=0, if_pc=0.
  - imem_req=0 during reset and in S_RESET.
- S_RESET -> S_FETCH unconditionally.
- imem_req = !flush && (state==S_FETCH || (state==S_FULL && id_ready)).
- imem_addr = pc, always.
- Accept event: imem_req && imem_ack. On accept:
  - if_instr<=imem_rdata, if_pc<=pc, if_valid<=1.
  - pc<=pc_next_in.
  - Next state S_FULL.
  - Zero-wait memory gives back-to-back accepts at 1 instruction/cycle while id_ready=1.
- S_FETCH without ack: hold pc and the request. IF/ID is empty in this state, so if_valid=0.
- S_FULL:
  - id_ready=1 and no accept: if_valid<=0, next state S_FETCH.
  - id_ready=1 with accept: the accept rule applies; stay in S_FULL.
  - id_ready=0: hold all IF/ID contents and pc, no request.
- Handshake rules:
  - if_instr and if_pc are stable while if_valid && !id_ready.
  - imem_req and imem_addr are stable until ack unless a flush occurs.
  - pc_next_in is sampled only in the accept cycle.
- Flush, second priority after reset:
  - if_valid<=0, pc<=flush_pc, state<=S_FETCH.
  - imem_req is forced 0 that cycle.
  - An imem_ack coincident with flush is discarded, and pc_next_in is ignored.
  - Instruction memory must drop an unacknowledged request when req falls.
- Arithmetic: none internal; PC wraps naturally via the next-PC unit. Widths are fixed by parameters with no truncation.
- Reset asserted mid-request aborts it identically to flush, then applies the S_RESET bubble.

Decomposition:
- Shared cpu package holds:
  - the state enum (S_RESET, S_FETCH, S_FULL);
  - RESET_PC default;
  - the INSTR_WIDTH and PC_WIDTH constants, also used by the next-PC unit and decode.
- Natural sub-module: if_id_reg, the IF/ID pipeline register with load/hold/clear controls.
- PC register and FSM stay in the top-level block.

Test Plan:
1. Reset then zero-wait memory, id_ready=1, pc_next_in=pc+1 model: imem_addr 0,1,2,3 on consecutive cycles after one bubble; if_pc 0,1,2 with if_valid continuously 1.
2. Memory with 3-cycle ack latency at addr 5: imem_req and imem_addr=5 held for 3 cycles; if_valid=0 until the ack; the cycle after, if_pc=5 and pc=pc_next_in value.
3. id_ready=0 for 4 cycles with if_instr=0xE3A01005: if_instr, if_pc and pc unchanged; imem_req=0 throughout; on id_ready=1, a new request issues that same cycle.
4. Branch: pc_next_in=234+500=734 in the accept cycle of pc=234: next imem_addr=734.
5. Flush with flush_pc=0x40 in the same cycle as imem_ack: ack discarded, if_valid=0 next cycle, imem_req=0 that cycle, next request addr=0x40.
6. reset asserted while S_FULL with a pending request: next cycle if_valid=0 and pc=RESET_PC, one bubble, then request to RESET_PC.
